// File: rtl/fwd_mux_stage_pkg.sv
// Shared definitions for the forwarding select stage: default widths,
// forwarding source encodings and a saturating counter helper.
package fwd_mux_stage_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_NSRC  = 4;
    localparam int DEF_NCH   = 2;
    localparam int CNT_W     = 16;

    // Source index encodings used when the stage does EX-stage operand forwarding
    typedef enum logic [1:0] {
        SRC_RF  = 2'd0,
        SRC_EX  = 2'd1,
        SRC_MEM = 2'd2,
        SRC_WB  = 2'd3
    } fwd_src_e;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == {CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/fwd_mux_stage_mux_n.sv
// Combinational N:1 word mux. A select value with no matching source
// (only possible when NSRC is not a power of two) falls back to source 0
// and raises oor so the caller can record the event.
module mux_n
    import fwd_mux_stage_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NSRC  = DEF_NSRC,
    parameter int SELW  = $clog2(NSRC)
) (
    input  logic [NSRC*WIDTH-1:0] d,
    input  logic [SELW-1:0]       sel,
    output logic [WIDTH-1:0]      y,
    output logic                  oor
);

    // Scan every source; a hit replaces the source-0 fallback and clears oor
    always_comb begin
        y   = d[WIDTH-1:0];
        oor = 1'b1;
        for (int k = 0; k < NSRC; k++) begin
            y   = (sel == SELW'(k)) ? d[k*WIDTH +: WIDTH] : y;
            oor = (sel == SELW'(k)) ? 1'b0 : oor;
        end
    end

endmodule

// File: rtl/fwd_mux_stage.sv
// Registered multi-channel source select stage. Each channel picks one of
// the shared source words; the results sit in a one-entry register with a
// valid/ready handshake, flush, sticky out-of-range flags and a stall counter.
module fwd_mux_stage
    import fwd_mux_stage_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NSRC  = DEF_NSRC,
    parameter int NCH   = DEF_NCH,
    parameter int SELW  = $clog2(NSRC)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NSRC*WIDTH-1:0] d,
    input  logic [NCH*SELW-1:0]   sel,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NCH*WIDTH-1:0]  y,
    output logic [NCH-1:0]        sel_err,
    output logic [CNT_W-1:0]      stall_cnt
);

    logic [NCH*WIDTH-1:0] mux_y_s;
    logic [NCH-1:0]       mux_oor_s;
    logic                 accept_s;
    logic                 transfer_s;
    logic                 stall_s;

    logic                 out_valid_r;
    logic [NCH*WIDTH-1:0] y_r;
    logic [NCH-1:0]       sel_err_r;
    logic [CNT_W-1:0]     stall_cnt_r;

    // One independent mux per channel, all fed by the same source bus
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        mux_n #(
            .WIDTH (WIDTH),
            .NSRC  (NSRC),
            .SELW  (SELW)
        ) u_mux (
            .d   (d),
            .sel (sel[c*SELW +: SELW]),
            .y   (mux_y_s[c*WIDTH +: WIDTH]),
            .oor (mux_oor_s[c])
        );
    end

    // in_ready is the only combinational output; it never looks at d or sel
    assign in_ready   = !flush && (!out_valid_r || out_ready);
    assign accept_s   = in_valid && in_ready;
    assign transfer_s = out_valid_r && out_ready;
    assign stall_s    = out_valid_r && !out_ready && !flush;

    // Entry-valid flag: flush kills the entry, accept fills it, transfer empties it
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r <= 1'b0;
        end else if (flush) begin
            out_valid_r <= 1'b0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
        end else if (transfer_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Result register only moves on accept, so y holds across drains and flushes
    always_ff @(posedge clk) begin
        if (reset) begin
            y_r <= {(NCH*WIDTH){1'b0}};
        end else if (accept_s) begin
            y_r <= mux_y_s;
        end else begin
            y_r <= y_r;
        end
    end

    // Sticky per-channel flags for accepted out-of-range selects
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_err_r <= {NCH{1'b0}};
        end else if (accept_s) begin
            sel_err_r <= sel_err_r | mux_oor_s;
        end else begin
            sel_err_r <= sel_err_r;
        end
    end

    // Saturating count of cycles where a valid result is blocked downstream
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stall_s) begin
            stall_cnt_r <= sat_inc(stall_cnt_r);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign out_valid = out_valid_r;
    assign y         = y_r;
    assign sel_err   = sel_err_r;
    assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_fwd_mux_stage.sv
// Scoreboard bench for fwd_mux_stage: a 4-source/2-channel instance under
// directed and random traffic against a transaction-level model, plus a
// 3-source instance for the out-of-range select rule.
module tb_fwd_mux_stage;
    import fwd_mux_stage_pkg::*;

    localparam int W  = 32;
    localparam int NS = 4;
    localparam int NC = 2;
    localparam int SW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 4-source instance
    logic            reset, in_valid, flush, out_ready;
    logic [NS*W-1:0] d;
    logic [NC*SW-1:0] sel;
    logic            in_ready, out_valid;
    logic [NC*W-1:0] y;
    logic [NC-1:0]   sel_err;
    logic [15:0]     stall_cnt;

    // 3-source, 8-bit instance
    logic            reset_b, in_valid_b, flush_b, out_ready_b;
    logic [23:0]     d_b;
    logic [3:0]      sel_b;
    logic            in_ready_b, out_valid_b;
    logic [15:0]     y_b;
    logic [1:0]      sel_err_b;
    logic [15:0]     stall_cnt_b;

    fwd_mux_stage #(.WIDTH(W), .NSRC(NS), .NCH(NC)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .d(d), .sel(sel), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .y(y), .sel_err(sel_err), .stall_cnt(stall_cnt)
    );

    fwd_mux_stage #(.WIDTH(8), .NSRC(3), .NCH(2)) dut_b (
        .clk(clk), .reset(reset_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .d(d_b), .sel(sel_b), .flush(flush_b), .out_valid(out_valid_b),
        .out_ready(out_ready_b), .y(y_b), .sel_err(sel_err_b), .stall_cnt(stall_cnt_b)
    );

    int n_vec = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    // Reference model state: one held entry plus the scoreboard of undelivered results
    bit           m_valid = 1'b0;
    logic [63:0]  m_y = 64'd0;
    int           m_stall = 0;
    logic [63:0]  sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expected channel words: unpack the sources into an array and index it
    function automatic logic [63:0] ref_bundle(input logic [127:0] dv, input logic [3:0] sv);
        logic [31:0] src [4];
        logic [63:0] r;
        for (int k = 0; k < 4; k++) src[k] = dv[k*32 +: 32];
        for (int c = 0; c < 2; c++) r[c*32 +: 32] = src[sv[c*2 +: 2]];
        return r;
    endfunction

    // Transaction-level model, advanced on each rising edge with the pre-edge inputs
    initial begin
        bit m_rdy;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_valid = 1'b0;
                m_y     = 64'd0;
                m_stall = 0;
                sb.delete();
            end else begin
                m_rdy = !flush && (!m_valid || out_ready);
                if (m_valid && !out_ready && !flush && m_stall < 65535) m_stall++;
                if (flush) begin
                    m_valid = 1'b0;
                    sb.delete();
                end else if (in_valid && m_rdy) begin
                    m_y     = ref_bundle(d, sel);
                    m_valid = 1'b1;
                    sb.push_back(m_y);
                end else if (m_valid && out_ready) begin
                    m_valid = 1'b0;
                end
            end
        end
    end

    // Monitor: compares visible state and pops the scoreboard on each transfer
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
                chk("y", y, m_y);
                chk("in_ready", {63'd0, in_ready}, {63'd0, (!flush && (!m_valid || out_ready))});
                chk("stall_cnt", {48'd0, stall_cnt}, 64'(m_stall));
                chk("sel_err", {62'd0, sel_err}, 64'd0);
                if (out_valid && out_ready && !flush && !reset) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL sb_underflow: got output %0h, expected no output", y);
                    end else begin
                        e = sb.pop_front();
                        chk("sb_y", y, e);
                    end
                end
            end
        end
    end

    initial begin
        logic [63:0] exp_last;
        logic [63:0] exp_a;

        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        d = '0; sel = '0;
        reset_b = 1'b1; in_valid_b = 1'b0; flush_b = 1'b0; out_ready_b = 1'b1;
        d_b = '0; sel_b = '0;

        // Reset then idle
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0; reset_b = 1'b0;
        #1;
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_y", y, 64'd0);
        chk("rst_sel_err", {62'd0, sel_err}, 64'd0);
        chk("rst_stall", {48'd0, stall_cnt}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        mon_en = 1'b1;

        // Basic select
        d = {32'd40, 32'd30, 32'd20, 32'd10};
        sel = {2'd3, 2'd1};
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("basic_valid", {63'd0, out_valid}, 64'd1);
        chk("basic_y", y, {32'd40, 32'd20});

        // Streaming: eight back-to-back bundles, no bubbles
        exp_last = 64'd0;
        for (int i = 0; i < 8; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            sel = 4'($urandom);
            in_valid = 1'b1;
            exp_last = ref_bundle(d, sel);
            @(posedge clk); #1;
            chk("stream_valid", {63'd0, out_valid}, 64'd1);
            chk("stream_y", y, exp_last);
        end

        // Backpressure: five blocked cycles with a pending bundle offered
        out_ready = 1'b0;
        d = {$urandom, $urandom, $urandom, $urandom};
        sel = 4'($urandom);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_y", y, exp_last);
            chk("bp_valid", {63'd0, out_valid}, 64'd1);
            chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
        end
        chk("bp_stall", {48'd0, stall_cnt}, 64'd5);
        out_ready = 1'b1; in_valid = 1'b0;
        #1;
        chk("bp_release", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        chk("bp_drained", {63'd0, out_valid}, 64'd0);

        // Flush: held entry plus a pending bundle
        d = {$urandom, $urandom, $urandom, $urandom};
        sel = 4'($urandom);
        exp_a = ref_bundle(d, sel);
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        chk("fl_load", y, exp_a);
        flush = 1'b1;
        d = ~d;
        sel = ~sel;
        #1;
        chk("fl_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("fl_valid", {63'd0, out_valid}, 64'd0);
        chk("fl_y", y, exp_a);
        chk("fl_stall", {48'd0, stall_cnt}, 64'd5);

        // Out-of-range selects on the 3-source instance
        d_b = {8'h33, 8'h22, 8'h55};
        sel_b = {2'd1, 2'd3};
        in_valid_b = 1'b1;
        @(posedge clk); #1;
        in_valid_b = 1'b0;
        chk("oor_valid", {63'd0, out_valid_b}, 64'd1);
        chk("oor_y", {48'd0, y_b}, {48'd0, 8'h22, 8'h55});
        chk("oor_err", {62'd0, sel_err_b}, 64'd1);
        sel_b = {2'd2, 2'd0};
        in_valid_b = 1'b1;
        @(posedge clk); #1;
        in_valid_b = 1'b0;
        chk("oor_inrange_y", {48'd0, y_b}, {48'd0, 8'h33, 8'h55});
        chk("oor_sticky", {62'd0, sel_err_b}, 64'd1);
        sel_b = {2'd3, 2'd2};
        in_valid_b = 1'b1;
        @(posedge clk); #1;
        in_valid_b = 1'b0;
        chk("oor_ch1_y", {48'd0, y_b}, {48'd0, 8'h55, 8'h33});
        chk("oor_ch1_err", {62'd0, sel_err_b}, 64'd3);
        chk("oor_stall", {48'd0, stall_cnt_b}, 64'd0);
        reset_b = 1'b1;
        @(posedge clk); #1;
        reset_b = 1'b0;
        chk("oor_rst_err", {62'd0, sel_err_b}, 64'd0);
        chk("oor_rst_y", {48'd0, y_b}, 64'd0);
        chk("oor_rst_valid", {63'd0, out_valid_b}, 64'd0);
        chk("oor_rst_ready", {63'd0, in_ready_b}, 64'd1);

        // Random traffic with occasional flush and mid-run reset
        for (int i = 0; i < 600; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            sel = 4'($urandom);
            in_valid = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush = ($urandom_range(0, 19) == 0);
            reset = ($urandom_range(0, 99) == 0);
            @(posedge clk); #1;
        end
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("end_drained", {63'd0, out_valid}, 64'd0);
        chk("end_sb_empty", 64'(sb.size()), 64'd0);
        mon_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
